// File: rtl/audio_i2s_pkg.sv
// Shared constants for the WM8731 I2S DAC path.
// Frame geometry (64 BCLK per frame, 32 per slot) and BCLK toggle rates per sample rate.
// rate_inc() maps the sample-rate select onto a phase-accumulator increment.
package audio_i2s_pkg;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DATA_W     = 16;

    // Phase increment per clk is the BCLK toggle rate (2 * 64 * Fs) in Hz.
    localparam int INC_W = 24;
    localparam logic [INC_W-1:0] BCLK_TOGGLE_48K = 24'd6_144_000;
    localparam logic [INC_W-1:0] BCLK_TOGGLE_96K = 24'd12_288_000;

    function automatic logic [INC_W-1:0] rate_inc(input logic rate_96k);
        return rate_96k ? BCLK_TOGGLE_96K : BCLK_TOGGLE_48K;
    endfunction

endpackage

// File: rtl/audio_i2s_tx_frac_tick_gen.sv
// Fractional clock divider: tick is asserted in clk cycles where the phase accumulator wraps.
// Latency: tick is combinational from the current accumulator and inc (same-cycle).
// No backpressure; free-running whenever reset is low.
//
// Ports: clk, reset (async, active-high), inc (phase step per clk, Hz), tick (wrap pulse).
module frac_tick_gen #(
    parameter int CLK_RATE = 50_000_000,
    parameter int INC_W    = audio_i2s_pkg::INC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INC_W-1:0] inc,
    output logic             tick
);

    // One spare bit over clog2(CLK_RATE) so acc + inc can never overflow.
    localparam int ACC_W = $clog2(CLK_RATE) + 1;
    localparam int unsigned LIMIT_I = CLK_RATE;
    localparam logic [ACC_W:0] LIMIT = LIMIT_I[ACC_W:0];

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum     = {1'b0, acc} + {{(ACC_W + 1 - INC_W){1'b0}}, inc};
        tick    = (sum >= LIMIT);
        // Remainder carries over, so the long-run tick rate is exact.
        acc_nxt = tick ? ACC_W'(sum - LIMIT) : ACC_W'(sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the WM8731 DAC: serialises a stereo sample pair per 64-BCLK frame.
// Latency: samples captured at frame start (BCLK fall, n==0); left MSB appears one BCLK later.
// No backpressure: inputs are sampled once per frame, signalled by sample_strobe.
//
// Ports: clk, reset (async, active-high), sample_rate (0=48k, 1=96k, applied at frame start),
//        left_in/right_in (two's complement), i2s_bclk/i2s_lrclk/i2s_data, sample_strobe.
module audio_i2s_tx #(
    parameter int CLK_RATE  = 50_000_000,
    parameter int DATA_W    = audio_i2s_pkg::DATA_W,
    parameter int SLOT_BITS = audio_i2s_pkg::SLOT_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_rate,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    output logic              i2s_bclk,
    output logic              i2s_lrclk,
    output logic              i2s_data,
    output logic              sample_strobe
);

    import audio_i2s_pkg::*;

    localparam int FRAME_N = 2 * SLOT_BITS;
    localparam int CNT_W   = $clog2(FRAME_N);

    localparam logic [CNT_W-1:0] N_START     = '0;
    localparam logic [CNT_W-1:0] N_LEFT_MSB  = CNT_W'(1);
    localparam logic [CNT_W-1:0] N_RIGHT_WS  = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] N_RIGHT_MSB = CNT_W'(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0] N_RESET     = CNT_W'(FRAME_N - 1);

    logic              tick;
    logic              rate_q;
    logic [INC_W-1:0]  inc;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] shreg;

    // rate_q only moves at frame start, so a rate change never splits a frame.
    assign inc = rate_inc(rate_q);

    frac_tick_gen #(
        .CLK_RATE (CLK_RATE),
        .INC_W    (INC_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .tick  (tick)
    );

    // Bit position of the slot being entered at the next BCLK fall; wraps at frame length.
    always_comb begin
        n = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i2s_bclk      <= 1'b0;
            i2s_lrclk     <= 1'b0;
            i2s_data      <= 1'b0;
            sample_strobe <= 1'b0;
            cnt           <= N_RESET;
            rate_q        <= 1'b0;
            hold_l        <= '0;
            hold_r        <= '0;
            shreg         <= '0;
        end else begin
            sample_strobe <= 1'b0;
            if (tick) begin
                i2s_bclk <= ~i2s_bclk;
                // Data side moves only on the 1->0 toggle so the codec samples on the rise.
                if (i2s_bclk) begin
                    cnt <= n;
                    if (n == N_START) begin
                        i2s_lrclk     <= 1'b0;
                        hold_l        <= left_in;
                        hold_r        <= right_in;
                        rate_q        <= sample_rate;
                        sample_strobe <= 1'b1;
                        i2s_data      <= 1'b0;
                    end else if (n == N_LEFT_MSB) begin
                        // MSB lags the word-select edge by one BCLK (I2S framing).
                        shreg    <= hold_l;
                        i2s_data <= hold_l[DATA_W-1];
                    end else if (n == N_RIGHT_WS) begin
                        i2s_lrclk <= 1'b1;
                        i2s_data  <= 1'b0;
                    end else if (n == N_RIGHT_MSB) begin
                        shreg    <= hold_r;
                        i2s_data <= hold_r[DATA_W-1];
                    end else begin
                        // Zero fill pads the slot tail after the LSB.
                        shreg    <= shreg << 1;
                        i2s_data <= shreg[DATA_W-2];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: frame timing, slot decoding, capture timing,
// rate switching and asynchronous reset, all against hand-computed values.
// Outputs are sampled 1 ns after each rising clk edge.
module tb_audio_i2s_tx;

    logic        clk;
    logic        reset;
    logic        sample_rate;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_data;
    logic        sample_strobe;

    int n_chk = 0;
    int n_err = 0;

    audio_i2s_tx dut (
        .clk           (clk),
        .reset         (reset),
        .sample_rate   (sample_rate),
        .left_in       (left_in),
        .right_in      (right_in),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_data      (i2s_data),
        .sample_strobe (sample_strobe)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string tag, output int t);
        t = 0;
        do begin
            step();
            t++;
        end while (!sample_strobe && t < 3000);
        chk({tag, "_strobe_seen"}, 32'(sample_strobe), 32'd1);
    endtask

    // Called in the cycle a strobe is visible; runs until the next strobe and decodes
    // the bits present on each BCLK rise (rise k follows the fall that entered bit n=k).
    task automatic capture_frame(input string tag, input bit chg_left, input logic [15:0] new_left,
                                 input bit chg_rate, input int hmin, input int hmax,
                                 output logic [15:0] l, output logic [15:0] r, output int len);
        int   rises;
        int   pad_e;
        int   lr_e;
        int   gl_e;
        int   per_e;
        int   last_tog;
        logic pb;
        logic pl;
        logic pd;
        bit   done;
        l = '0; r = '0; len = 0;
        rises = 0; pad_e = 0; lr_e = 0; gl_e = 0; per_e = 0; last_tog = 0;
        pb = i2s_bclk; pl = i2s_lrclk; pd = i2s_data; done = 0;
        while (!done && len < 3000) begin
            step();
            len++;
            if (chg_left && len == 1) left_in = new_left;
            if (i2s_bclk != pb) begin
                if (len - last_tog < hmin || len - last_tog > hmax) per_e++;
                last_tog = len;
            end
            if (!pb && i2s_bclk) begin
                if (rises >= 1 && rises <= 16)       l[16 - rises] = i2s_data;
                else if (rises >= 33 && rises <= 48) r[48 - rises] = i2s_data;
                else if (i2s_data)                   pad_e++;
                if (i2s_lrclk != (rises >= 32)) lr_e++;
                if (chg_rate && rises == 8) sample_rate = 1'b1;
                rises++;
            end
            if (!(pb && !i2s_bclk) && (i2s_lrclk != pl || i2s_data != pd)) gl_e++;
            pb = i2s_bclk; pl = i2s_lrclk; pd = i2s_data;
            if (sample_strobe) done = 1;
        end
        chk({tag, "_frame_end"}, 32'(done), 32'd1);
        chk({tag, "_rises"}, 32'(rises), 32'd64);
        chk({tag, "_pad_bits"}, 32'(pad_e), 32'd0);
        chk({tag, "_lrclk"}, 32'(lr_e), 32'd0);
        chk({tag, "_off_fall_change"}, 32'(gl_e), 32'd0);
        chk({tag, "_bclk_half_period"}, 32'(per_e), 32'd0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int len;
        int len2;
        int len3;
        logic [15:0] l;
        logic [15:0] r;

        reset = 1'b1; sample_rate = 1'b0;
        left_in = 16'hA5C3; right_in = 16'h3C5A;
        repeat (3) step();
        chk("rst_bclk",   32'(i2s_bclk),      32'd0);
        chk("rst_lrclk",  32'(i2s_lrclk),     32'd0);
        chk("rst_data",   32'(i2s_data),      32'd0);
        chk("rst_strobe", 32'(sample_strobe), 32'd0);

        // Reset release and 48 kHz frame timing.
        @(negedge clk); reset = 1'b0;
        wait_strobe("t1_first", t);
        chk("t1_first_strobe_le17", 32'(t <= 17), 32'd1);

        capture_frame("t1_f1", 1'b0, 16'h0, 1'b0, 8, 9, l, r, len);
        chk("t2_left",  32'(l), 32'hA5C3);
        chk("t2_right", 32'(r), 32'h3C5A);
        capture_frame("t1_f2", 1'b0, 16'h0, 1'b0, 8, 9, l, r, len2);
        capture_frame("t1_f3", 1'b0, 16'h0, 1'b0, 8, 9, l, r, len3);
        chk("t1_f1_len_ok", 32'(len >= 1041 && len <= 1042), 32'd1);
        chk("t1_3frames",   32'(len + len2 + len3), 32'd3125);
        chk("t2_f3_left",   32'(l), 32'hA5C3);

        // Input change one clk after capture only shows up in the next frame.
        capture_frame("t3_a", 1'b1, 16'h1234, 1'b0, 8, 9, l, r, len);
        chk("t3_cur_left",  32'(l), 32'hA5C3);
        chk("t3_cur_right", 32'(r), 32'h3C5A);
        left_in = 16'h8000; right_in = 16'h7FFF;
        capture_frame("t3_b", 1'b0, 16'h0, 1'b0, 8, 9, l, r, len);
        chk("t3_next_left",  32'(l), 32'h1234);
        chk("t3_next_right", 32'(r), 32'h3C5A);

        // Extreme values.
        capture_frame("t6", 1'b0, 16'h0, 1'b0, 8, 9, l, r, len);
        chk("t6_left",  32'(l), 32'h8000);
        chk("t6_right", 32'(r), 32'h7FFF);

        // Reset pulse during the right slot.
        left_in = 16'h0F0F; right_in = 16'hF0F0;
        t = 0;
        while (!i2s_lrclk && t < 2000) begin
            step();
            t++;
        end
        chk("t5_in_right_slot", 32'(i2s_lrclk), 32'd1);
        repeat (20) step();
        reset = 1'b1;
        #1;
        chk("t5_async_bclk",   32'(i2s_bclk),      32'd0);
        chk("t5_async_lrclk",  32'(i2s_lrclk),     32'd0);
        chk("t5_async_data",   32'(i2s_data),      32'd0);
        chk("t5_async_strobe", 32'(sample_strobe), 32'd0);
        left_in = 16'hC001; right_in = 16'h0FF0;
        repeat (2) step();
        chk("t5_held_lrclk", 32'(i2s_lrclk), 32'd0);
        chk("t5_held_bclk",  32'(i2s_bclk),  32'd0);
        @(negedge clk); reset = 1'b0;
        wait_strobe("t5_restart", t);
        chk("t5_restart_le17", 32'(t <= 17), 32'd1);
        capture_frame("t5", 1'b0, 16'h0, 1'b0, 8, 9, l, r, len);
        chk("t5_left",  32'(l), 32'hC001);
        chk("t5_right", 32'(r), 32'h0FF0);

        // 48k -> 96k switch requested mid-left-slot.
        capture_frame("t4_old", 1'b0, 16'h0, 1'b1, 8, 9, l, r, len);
        chk("t4_old_len_ok", 32'(len >= 1041 && len <= 1042), 32'd1);
        chk("t4_old_left",   32'(l), 32'hC001);
        capture_frame("t4_new1", 1'b0, 16'h0, 1'b0, 4, 5, l, r, len2);
        capture_frame("t4_new2", 1'b0, 16'h0, 1'b0, 4, 5, l, r, len3);
        chk("t4_new1_len_ok", 32'(len2 >= 520 && len2 <= 521), 32'd1);
        chk("t4_new2_len_ok", 32'(len3 >= 520 && len3 <= 521), 32'd1);
        chk("t4_2frames_ok",  32'(len2 + len3 >= 1041 && len2 + len3 <= 1043), 32'd1);
        chk("t4_new_right",   32'(r), 32'h0FF0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
